// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor update path: default PHT index
// width, 2-bit saturating counter encodings and the in-flight entry layout.
package bp_pkg;

    localparam int unsigned INDEX_WIDTH_DEFAULT = 12;

    localparam logic [1:0] STRONGLY_NOT_TAKEN = 2'b00;
    localparam logic [1:0] WEAKLY_NOT_TAKEN   = 2'b01;
    localparam logic [1:0] WEAKLY_TAKEN       = 2'b10;
    localparam logic [1:0] STRONGLY_TAKEN     = 2'b11;

    // Layout of one in-flight branch at the default index width; pred sits in bit 0.
    typedef struct packed {
        logic [INDEX_WIDTH_DEFAULT-1:0] index;
        logic                           pred;
    } bp_entry_t;

endpackage

// File: rtl/bp_sync_fifo.sv
// Synchronous FIFO holding in-flight branch entries. Head data is read
// combinationally; flush clears occupancy while still honouring a same-cycle pop.
module bp_sync_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Next pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_en_i) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(wr_en_i) - CW'(rd_en_i);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/br_update_queue.sv
// Tracks predicted branches between fetch and execute and turns each
// resolution into a registered PHT update strobe with a mispredict flag.
module br_update_queue
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = INDEX_WIDTH_DEFAULT,
    parameter int unsigned DEPTH       = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_valid_i,
    input  logic [INDEX_WIDTH-1:0]   push_index_i,
    input  logic                     push_pred_i,
    output logic                     push_ready_o,
    input  logic                     resolve_valid_i,
    input  logic                     resolve_taken_i,
    input  logic                     flush_i,
    output logic                     update_en_o,
    output logic [INDEX_WIDTH-1:0]   update_index_o,
    output logic                     br_taken_o,
    output logic                     mispredict_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     underflow_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = INDEX_WIDTH + 1;

    logic [CW-1:0]          count;
    logic [EW-1:0]          push_entry;
    logic [EW-1:0]          head_entry;
    logic [INDEX_WIDTH-1:0] head_index;
    logic                   head_pred;
    logic                   push_acc;
    logic                   resolve_acc;
    logic                   queue_empty;

    logic                   update_en_q, update_en_d;
    logic [INDEX_WIDTH-1:0] update_index_q, update_index_d;
    logic                   br_taken_q, br_taken_d;
    logic                   mispredict_q, mispredict_d;
    logic                   underflow_q, underflow_d;

    assign push_entry  = {push_index_i, push_pred_i};
    assign head_index  = head_entry[EW-1:1];
    assign head_pred   = head_entry[0];
    assign queue_empty = (count == '0);

    // Readiness looks only at occupancy, so a same-cycle resolve never frees a slot for a push.
    assign push_ready_o = (count != CW'(DEPTH));
    assign push_acc     = push_valid_i && push_ready_o && !flush_i;
    assign resolve_acc  = resolve_valid_i && !queue_empty;

    bp_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (push_acc),
        .wr_data_i (push_entry),
        .rd_en_i   (resolve_acc),
        .flush_i   (flush_i),
        .rd_data_o (head_entry),
        .count_o   (count)
    );

    // Update outputs for the next cycle; index and direction hold when nothing resolves.
    always_comb begin
        update_en_d    = resolve_acc;
        update_index_d = update_index_q;
        br_taken_d     = br_taken_q;
        mispredict_d   = 1'b0;
        underflow_d    = underflow_q | (resolve_valid_i & queue_empty);
        if (resolve_acc) begin
            update_index_d = head_index;
            br_taken_d     = resolve_taken_i;
            mispredict_d   = (head_pred != resolve_taken_i);
        end
    end

    // Output registers; reset also swallows an update that would otherwise issue next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            update_en_q    <= 1'b0;
            update_index_q <= '0;
            br_taken_q     <= 1'b0;
            mispredict_q   <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            update_en_q    <= update_en_d;
            update_index_q <= update_index_d;
            br_taken_q     <= br_taken_d;
            mispredict_q   <= mispredict_d;
            underflow_q    <= underflow_d;
        end
    end

    assign update_en_o    = update_en_q;
    assign update_index_o = update_index_q;
    assign br_taken_o     = br_taken_q;
    assign mispredict_o   = mispredict_q;
    assign underflow_o    = underflow_q;
    assign count_o        = count;

endmodule
